// File: rtl/sw_word_loader.sv
// Captures the SW word on a debounced KEY_n press and offers it on a valid/ready write port with an auto-incrementing address.
// Optional SW_LOADER_HEX_ECHO_EN adds registered seven-segment echo outputs HEX3..HEX0 of the captured word.
module sw_word_loader #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ADDR_W          = 7
) (
    input  logic              CLOCK_50,
    input  logic              Reset,
    input  logic [15:0]       SW,
    input  logic              KEY_n,
    output logic [15:0]       WrData,
    output logic [ADDR_W-1:0] WrAddr,
    output logic              WrValid,
    input  logic              WrReady,
    output logic              Full
`ifdef SW_LOADER_HEX_ECHO_EN
    ,
    output logic [6:0]        HEX3,
    output logic [6:0]        HEX2,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX0
`endif
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

    state_t           state;
    state_t           state_next;
    logic             key_p0;
    logic             key_p1;
    logic [CNT_W-1:0] db_cnt;
    logic             db_level;
    logic             db_level_p2;
    logic             press;
    logic             capture;
    logic             accept;

    // Stage p0/p1: two-flop synchroniser for the raw pushbutton
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            key_p0 <= 1'b1;
            key_p1 <= 1'b1;
        end else begin
            key_p0 <= KEY_n;
            key_p1 <= key_p0;
        end
    end

    // Stage p2: debounced level; the previous level is kept to find the falling edge
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            db_cnt      <= '0;
            db_level    <= 1'b1;
            db_level_p2 <= 1'b1;
        end else begin
            db_level_p2 <= db_level;
            if (key_p1 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
                db_level <= key_p1;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press   = db_level_p2 & ~db_level;
    assign WrValid = (state == SEND);
    assign accept  = WrValid & WrReady;

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (press && !Full) begin
                    state_next = SEND;
                    capture    = 1'b1;
                end
            end
            SEND: begin
                if (WrReady) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                // Wait for the button to come back up so one press yields one word
                if (db_level) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            WrData <= 16'h0000;
            WrAddr <= '0;
            Full   <= 1'b0;
        end else begin
            if (capture) begin
                WrData <= SW;
            end
            if (accept) begin
                if (WrAddr == ADDR_LAST) begin
                    Full <= 1'b1;
                end else begin
                    WrAddr <= WrAddr + 1'b1;
                end
            end
        end
    end

`ifdef SW_LOADER_HEX_ECHO_EN
    function automatic logic [6:0] hex_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            HEX3 <= 7'b1000000;
            HEX2 <= 7'b1000000;
            HEX1 <= 7'b1000000;
            HEX0 <= 7'b1000000;
        end else begin
            HEX3 <= hex_seg(WrData[15:12]);
            HEX2 <= hex_seg(WrData[11:8]);
            HEX1 <= hex_seg(WrData[7:4]);
            HEX0 <= hex_seg(WrData[3:0]);
        end
    end
`endif

endmodule

// File: tb/tb_sw_word_loader.sv
// Randomised self-checking bench for sw_word_loader with DEBOUNCE_CYCLES=4, ADDR_W=2.
// Define SW_LOADER_HEX_ECHO_EN to also exercise the seven-segment echo outputs.
module tb_sw_word_loader;

    localparam int DEB = 4;
    localparam int AW  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   sw;
    logic          key_n;
    logic          wr_ready;
    logic [15:0]   wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_valid;
    logic          full;
`ifdef SW_LOADER_HEX_ECHO_EN
    logic [6:0]    hex3, hex2, hex1, hex0;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: next write address and full flag derived from the count of accepted words
    int model_accepts = 0;
    int pulses        = 0;
    logic prev_valid  = 1'b0;
    logic [15:0] acc_data_q[$];
    int          acc_addr_q[$];

    sw_word_loader #(.DEBOUNCE_CYCLES(DEB), .ADDR_W(AW)) dut (
        .CLOCK_50 (clk),
        .Reset    (rst),
        .SW       (sw),
        .KEY_n    (key_n),
        .WrData   (wr_data),
        .WrAddr   (wr_addr),
        .WrValid  (wr_valid),
        .WrReady  (wr_ready),
        .Full     (full)
`ifdef SW_LOADER_HEX_ECHO_EN
        ,
        .HEX3     (hex3),
        .HEX2     (hex2),
        .HEX1     (hex1),
        .HEX0     (hex0)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        prev_valid <= wr_valid;
        if (wr_valid && !prev_valid) pulses <= pulses + 1;
        if (!rst && wr_valid && wr_ready) begin
            acc_data_q.push_back(wr_data);
            acc_addr_q.push_back(int'(wr_addr));
        end
    end

    function automatic int model_addr();
        return (model_accepts >= (1 << AW)) ? (1 << AW) - 1 : model_accepts;
    endfunction

    function automatic logic model_full();
        return model_accepts >= (1 << AW);
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (wr_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; key_n = 1'b1; wr_ready = 1'b0; sw = 16'($urandom);
        tick(2);
        vectors++; if (wr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", wr_valid); end
        vectors++; if (wr_addr !== '0) begin miscompares++; $display("FAIL reset_addr got %0d want 0", wr_addr); end
        vectors++; if (wr_data !== 16'h0000) begin miscompares++; $display("FAIL reset_data got %h want 0000", wr_data); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", full); end
`ifdef SW_LOADER_HEX_ECHO_EN
        vectors++; if ({hex3, hex2, hex1, hex0} !== {4{7'b1000000}}) begin
            miscompares++; $display("FAIL reset_hex got %h want %h", {hex3, hex2, hex1, hex0}, {4{7'b1000000}});
        end
`endif
        rst = 1'b0;
        model_accepts = 0;
        tick(2);
    endtask

    task automatic test_clean_press();
        int p0;
        acc_data_q.delete(); acc_addr_q.delete();
        p0 = pulses;
        sw = 16'hBEEF; wr_ready = 1'b1;
        key_n = 1'b0; tick(10);
        key_n = 1'b1; tick(12);
        vectors++; if (pulses - p0 != 1) begin miscompares++; $display("FAIL clean_pulses got %0d want 1", pulses - p0); end
        vectors++;
        if (acc_data_q.size() != 1) begin
            miscompares++; $display("FAIL clean_accepts got %0d want 1", acc_data_q.size());
        end else if (acc_data_q[0] !== 16'hBEEF || acc_addr_q[0] != model_addr()) begin
            miscompares++; $display("FAIL clean_word got %h@%0d want %h@%0d", acc_data_q[0], acc_addr_q[0], 16'hBEEF, model_addr());
        end
        model_accepts++;
        vectors++; if (int'(wr_addr) != model_addr()) begin miscompares++; $display("FAIL clean_addr_after got %0d want %0d", wr_addr, model_addr()); end
        wr_ready = 1'b0;
    endtask

    task automatic test_bounce();
        int p0;
        acc_data_q.delete(); acc_addr_q.delete();
        p0 = pulses;
        sw = 16'($urandom); wr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            key_n = 1'b0; tick(2);
            key_n = 1'b1; tick(2);
        end
        tick(12);
        vectors++; if (pulses != p0) begin miscompares++; $display("FAIL bounce_pulses got %0d want 0", pulses - p0); end
        vectors++; if (acc_data_q.size() != 0) begin miscompares++; $display("FAIL bounce_accepts got %0d want 0", acc_data_q.size()); end
        vectors++; if (int'(wr_addr) != model_addr()) begin miscompares++; $display("FAIL bounce_addr got %0d want %0d", wr_addr, model_addr()); end
        wr_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int a0;
        acc_data_q.delete(); acc_addr_q.delete();
        a0 = model_addr();
        sw = 16'hBEEF; wr_ready = 1'b0;
        key_n = 1'b0;
        wait_valid(30, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL bp_valid_timeout got 0 want 1"); end
        key_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            sw = (i == 0) ? 16'h1234 : 16'($urandom);
            tick();
            vectors++;
            if (wr_valid !== 1'b1 || wr_data !== 16'hBEEF || int'(wr_addr) != a0) begin
                miscompares++; $display("FAIL bp_hold got v=%b %h@%0d want v=1 %h@%0d", wr_valid, wr_data, wr_addr, 16'hBEEF, a0);
            end
        end
        wr_ready = 1'b1; tick(); wr_ready = 1'b0;
        vectors++;
        if (acc_data_q.size() != 1) begin
            miscompares++; $display("FAIL bp_accepts got %0d want 1", acc_data_q.size());
        end else if (acc_data_q[0] !== 16'hBEEF || acc_addr_q[0] != a0) begin
            miscompares++; $display("FAIL bp_word got %h@%0d want %h@%0d", acc_data_q[0], acc_addr_q[0], 16'hBEEF, a0);
        end
        model_accepts++;
        vectors++; if (wr_valid !== 1'b0) begin miscompares++; $display("FAIL bp_valid_drop got %b want 0", wr_valid); end
        vectors++; if (int'(wr_addr) != model_addr()) begin miscompares++; $display("FAIL bp_addr_after got %0d want %0d", wr_addr, model_addr()); end
        tick(12);
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        int first_seen;
        logic [15:0] v2;
        acc_data_q.delete(); acc_addr_q.delete();
        sw = 16'($urandom); wr_ready = 1'b0;
        key_n = 1'b0;
        wait_valid(30, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rms_valid_timeout got 0 want 1"); end
        rst = 1'b1;
        #1;
        vectors++; if (wr_valid !== 1'b0) begin miscompares++; $display("FAIL rms_valid_async got %b want 0", wr_valid); end
        vectors++; if (wr_addr !== '0) begin miscompares++; $display("FAIL rms_addr got %0d want 0", wr_addr); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL rms_full got %b want 0", full); end
        model_accepts = 0;
        tick();
        rst = 1'b0;
        v2 = 16'($urandom);
        sw = v2;
        first_seen = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (wr_valid && first_seen == 0) first_seen = i;
        end
        vectors++; if (first_seen == 0) begin miscompares++; $display("FAIL rms_press_timeout got none want press"); end
        vectors++; if (first_seen != 0 && first_seen <= DEB) begin miscompares++; $display("FAIL rms_press_early got cycle %0d want > %0d", first_seen, DEB); end
        wr_ready = 1'b1; tick(); wr_ready = 1'b0;
        key_n = 1'b1;
        vectors++;
        if (acc_data_q.size() != 1) begin
            miscompares++; $display("FAIL rms_accepts got %0d want 1", acc_data_q.size());
        end else if (acc_data_q[0] !== v2 || acc_addr_q[0] != model_addr()) begin
            miscompares++; $display("FAIL rms_word got %h@%0d want %h@%0d", acc_data_q[0], acc_addr_q[0], v2, model_addr());
        end
        model_accepts++;
        tick(12);
    endtask

    task automatic test_fill();
        bit ok;
        int p0;
        int stall;
        logic [15:0] v;
        rst = 1'b1; key_n = 1'b1; wr_ready = 1'b0; tick(); rst = 1'b0; tick(2);
        model_accepts = 0;
        for (int n = 0; n < (1 << AW); n++) begin
            acc_data_q.delete(); acc_addr_q.delete();
            p0 = pulses;
            v = 16'($urandom); sw = v; wr_ready = 1'b0;
            key_n = 1'b0;
            wait_valid(30, ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL fill%0d_valid_timeout got 0 want 1", n); end
            vectors++; if (full !== model_full()) begin miscompares++; $display("FAIL fill%0d_full_early got %b want %b", n, full, model_full()); end
            stall = $urandom_range(1, 5);
            for (int i = 0; i < stall; i++) begin
                sw = 16'($urandom);
                tick();
                vectors++;
                if (wr_valid !== 1'b1 || wr_data !== v) begin
                    miscompares++; $display("FAIL fill%0d_hold got v=%b %h want v=1 %h", n, wr_valid, wr_data, v);
                end
            end
            if (n == 1) begin
                // A full release and re-press while the word is still pending must be dropped
                key_n = 1'b1; tick(10);
                key_n = 1'b0; tick(10);
            end
            wr_ready = 1'b1; tick(); wr_ready = 1'b0;
            key_n = 1'b1; tick(12);
            vectors++;
            if (acc_data_q.size() != 1) begin
                miscompares++; $display("FAIL fill%0d_accepts got %0d want 1", n, acc_data_q.size());
            end else if (acc_data_q[0] !== v || acc_addr_q[0] != model_addr()) begin
                miscompares++; $display("FAIL fill%0d_word got %h@%0d want %h@%0d", n, acc_data_q[0], acc_addr_q[0], v, model_addr());
            end
            vectors++; if (pulses - p0 != 1) begin miscompares++; $display("FAIL fill%0d_pulses got %0d want 1", n, pulses - p0); end
            model_accepts++;
            vectors++; if (int'(wr_addr) != model_addr()) begin miscompares++; $display("FAIL fill%0d_addr got %0d want %0d", n, wr_addr, model_addr()); end
            vectors++; if (full !== model_full()) begin miscompares++; $display("FAIL fill%0d_full got %b want %b", n, full, model_full()); end
        end
        p0 = pulses;
        sw = 16'($urandom); wr_ready = 1'b1;
        key_n = 1'b0; tick(10);
        key_n = 1'b1; tick(12);
        wr_ready = 1'b0;
        vectors++; if (pulses != p0) begin miscompares++; $display("FAIL full_press_pulses got %0d want 0", pulses - p0); end
        vectors++; if (int'(wr_addr) != (1 << AW) - 1) begin miscompares++; $display("FAIL full_addr got %0d want %0d", wr_addr, (1 << AW) - 1); end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL full_flag got %b want 1", full); end
    endtask

`ifdef SW_LOADER_HEX_ECHO_EN
    task automatic test_hex();
        rst = 1'b1; key_n = 1'b1; wr_ready = 1'b0; tick(); rst = 1'b0; tick(2);
        model_accepts = 0;
        sw = 16'h0A5F; wr_ready = 1'b1;
        key_n = 1'b0; tick(10);
        key_n = 1'b1; tick(12);
        wr_ready = 1'b0;
        vectors++; if (hex3 !== 7'b1000000) begin miscompares++; $display("FAIL hex3 got %b want 1000000", hex3); end
        vectors++; if (hex2 !== 7'b0001000) begin miscompares++; $display("FAIL hex2 got %b want 0001000", hex2); end
        vectors++; if (hex1 !== 7'b0010010) begin miscompares++; $display("FAIL hex1 got %b want 0010010", hex1); end
        vectors++; if (hex0 !== 7'b0001110) begin miscompares++; $display("FAIL hex0 got %b want 0001110", hex0); end
    endtask
`endif

    initial begin
        rst = 1'b1; key_n = 1'b1; wr_ready = 1'b0; sw = 16'h0000;
        test_reset();
        test_clean_press();
        test_bounce();
        test_backpressure();
        test_reset_mid_send();
        test_fill();
`ifdef SW_LOADER_HEX_ECHO_EN
        test_hex();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
